// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_SEND   = 3'd2,
        ST_STROBE = 3'd3,
        ST_DRAIN  = 3'd4
    } uart_arb_state_t;

    localparam logic [7:0] UART_ARB_HDR_BASE = 8'hA0;
    localparam int         UART_ARB_MAX_REQ  = 8;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector, first valid after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] pick_onehot_o,
    output logic [ID_W-1:0]    pick_idx_o,
    output logic               pick_any_o
);

    logic            w_hi_found;
    logic            w_lo_found;
    logic [ID_W-1:0] w_hi_idx;
    logic [ID_W-1:0] w_lo_idx;

    // Descending scan leaves the lowest index of each region; the region above
    // last_grant has priority over the wrapped-around region.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                if (k > int'(last_grant)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(k);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = ID_W'(k);
                end
            end
        end
    end

    always_comb begin
        pick_any_o    = w_hi_found | w_lo_found;
        pick_idx_o    = w_hi_found ? w_hi_idx : w_lo_idx;
        pick_onehot_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_onehot_o[k] = pick_any_o && (ID_W'(k) == pick_idx_o);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-granular sharing of one UART transmitter.
//            Define UART_ARB_HDR_EN to prefix each packet with 0xA0|id.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_dat_o,
    input  logic                   uart_busy_i,
    output logic [NUM_REQ-1:0]     arb_grant_o,
    output logic                   arb_active_o
);

    uart_arb_state_t    r_state;
    uart_arb_state_t    w_state_nxt;

    logic [NUM_REQ-1:0] r_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last_grant;
    logic               r_last;
    logic [7:0]         r_dat;
    logic               r_wr;
    logic               r_active;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;

    logic               w_sel_valid;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_grant_ld;
    logic               w_take;
    logic               w_release;
`ifdef UART_ARB_HDR_EN
    logic               w_hdr_ld;
    logic [7:0]         w_hdr_byte;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_valid_i   (req_valid_i),
        .last_grant    (r_last_grant),
        .pick_onehot_o (w_pick_oh),
        .pick_idx_o    (w_pick_idx),
        .pick_any_o    (w_pick_any)
    );

    // Only the granted requester's lane is visible to the datapath.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_sel_valid = req_valid_i[k];
                w_sel_last  = req_last_i[k];
                w_sel_data  = req_data_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
`ifdef UART_ARB_HDR_EN
                    w_state_nxt = ST_HDR;
`else
                    w_state_nxt = ST_SEND;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR:    w_state_nxt = ST_STROBE;
`endif
            ST_SEND: begin
                if (w_sel_valid) begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!uart_busy_i) begin
                    w_state_nxt = r_last ? ST_IDLE : ST_SEND;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (r_state == ST_SEND) ? r_grant : '0;
        w_grant_ld  = (r_state == ST_IDLE) && w_pick_any;
        w_take      = (r_state == ST_SEND) && w_sel_valid;
        w_release   = (r_state == ST_DRAIN) && !uart_busy_i && r_last;
`ifdef UART_ARB_HDR_EN
        w_hdr_ld    = (r_state == ST_HDR);
        w_hdr_byte  = UART_ARB_HDR_BASE | 8'(r_grant_id);
`endif
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_last       <= 1'b0;
            r_dat        <= 8'h00;
            r_wr         <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (w_grant_ld) begin
                r_grant    <= w_pick_oh;
                r_grant_id <= w_pick_idx;
                r_active   <= 1'b1;
            end
`ifdef UART_ARB_HDR_EN
            // A header never ends a packet, so DRAIN always returns to SEND.
            if (w_hdr_ld) begin
                r_dat  <= w_hdr_byte;
                r_wr   <= 1'b1;
                r_last <= 1'b0;
            end
`endif
            if (w_take) begin
                r_dat  <= w_sel_data;
                r_wr   <= 1'b1;
                r_last <= w_sel_last;
            end
            if (w_release) begin
                r_last_grant <= r_grant_id;
                r_grant      <= '0;
                r_active     <= 1'b0;
                r_last       <= 1'b0;
            end
        end
    end

    assign uart_wr_o    = r_wr;
    assign uart_dat_o   = r_dat;
    assign arb_grant_o  = r_grant;
    assign arb_active_o = r_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter with a busy-pacing UART model.
//            Define UART_ARB_HDR_EN to expect packet header bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int BUSY_LEN = 44;
    localparam int LIM      = 4000;
`ifdef UART_ARB_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    typedef struct packed {
        logic [7:0] dat;
        logic [3:0] gnt;
    } exp_t;

    logic                 sys_clk_i = 1'b0;
    logic                 sys_rst_i = 1'b1;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic                 uart_wr_o;
    logic [7:0]           uart_dat_o;
    logic                 uart_busy_i;
    logic [NUM_REQ-1:0]   arb_grant_o;
    logic                 arb_active_o;

    logic [8:0]  src_q [NUM_REQ][$];
    exp_t        exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          last_gap = 0;
    logic        prev_wr = 1'b0;
    logic        force_busy = 1'b0;
    int          busy_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (3)
    ) dut (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .uart_wr_o    (uart_wr_o),
        .uart_dat_o   (uart_dat_o),
        .uart_busy_i  (uart_busy_i),
        .arb_grant_o  (arb_grant_o),
        .arb_active_o (arb_active_o)
    );

    always #42 sys_clk_i = ~sys_clk_i;

    always @(posedge sys_clk_i) cyc <= cyc + 1;

    // UART model: busy rises the cycle after the strobe and lasts BUSY_LEN cycles.
    always @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i)          busy_cnt <= 0;
        else if (uart_wr_o)     busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy_i = (busy_cnt != 0) || force_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        src_q[k].push_back({l, d});
    endtask

    task automatic expect_byte(input int k, input logic [7:0] d);
        exp_q.push_back({d, 4'(1 << k)});
    endtask

    task automatic expect_hdr(input int k);
        if (HDR_N != 0) expect_byte(k, 8'hA0 | 8'(k));
    endtask

    task automatic wait_q(input int k, input int n, input string nm);
        int t = 0;
        while (src_q[k].size() > n && t < LIM) begin
            @(negedge sys_clk_i);
            t++;
        end
        check(nm, 32'(t < LIM), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int t = 0;
        while (uart_busy_i !== lvl && t < LIM) begin
            @(negedge sys_clk_i);
            t++;
        end
        check(nm, 32'(t < LIM), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge sys_clk_i);
        while ((exp_q.size() != 0 || arb_active_o !== 1'b0) && t < LIM) begin
            @(negedge sys_clk_i);
            t++;
        end
        check(nm, 32'(t < LIM), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk_i);
        #2 sys_rst_i = 1'b1;
        repeat (3) @(posedge sys_clk_i);
        #2 sys_rst_i = 1'b0;
    endtask

    // Requester driver: pops on handshake, presents the head of each queue.
    initial begin
        logic [NUM_REQ-1:0] hs;
        logic [8:0]         ent;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        forever begin
            @(negedge sys_clk_i);
            hs = req_valid_i & req_ready_o;
            @(posedge sys_clk_i);
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (hs[k] && !sys_rst_i && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    ent                  = src_q[k][0];
                    req_valid_i[k]       = 1'b1;
                    req_data_i[8*k +: 8] = ent[7:0];
                    req_last_i[k]        = ent[8];
                end else begin
                    req_valid_i[k]       = 1'b0;
                    req_data_i[8*k +: 8] = 8'h00;
                    req_last_i[k]        = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge sys_clk_i) begin
        exp_t e;
        if (uart_wr_o === 1'b1) begin
            n_wr++;
            last_gap    = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            check("wr_single_cycle", 32'(prev_wr), 32'd0);
            check("wr_vs_busy", 32'(uart_busy_i), 32'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wr: got byte %0h, expected no strobe", uart_dat_o);
            end else begin
                e = exp_q.pop_front();
                check("uart_dat", 32'(uart_dat_o), 32'(e.dat));
                check("grant_at_wr", 32'(arb_grant_o), 32'(e.gnt));
            end
        end
        prev_wr = uart_wr_o;
    end

    initial begin
        #(84 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        // Reset values
        @(negedge sys_clk_i);
        check("rst_wr", 32'(uart_wr_o), 32'd0);
        check("rst_dat", 32'(uart_dat_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_grant", 32'(arb_grant_o), 32'd0);
        check("rst_active", 32'(arb_active_o), 32'd0);
        repeat (2) @(negedge sys_clk_i);
        sys_rst_i = 1'b0;

        // Two-byte packet from requester 0
        w0 = n_wr;
        expect_hdr(0);
        expect_byte(0, 8'h41);
        expect_byte(0, 8'h42);
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b1);
        wait_idle("t1_idle");
        check("t1_pulses", 32'(n_wr - w0), 32'(2 + HDR_N));
        check("t1_gap_ge_44", 32'(last_gap >= 44), 32'd1);
        check("t1_grant_drop", 32'(arb_grant_o), 32'd0);

        // Simultaneous requesters 1 and 2, twice
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            expect_hdr(1);
            expect_byte(1, 8'h11 + 8'(2 * r));
            expect_hdr(2);
            expect_byte(2, 8'h22 + 8'(2 * r));
            push_byte(1, 8'h11 + 8'(2 * r), 1'b1);
            push_byte(2, 8'h22 + 8'(2 * r), 1'b1);
            wait_idle("t2_idle");
        end

        // Requester 3 stalls mid-packet while requester 0 waits
        expect_hdr(3);
        expect_byte(3, 8'h31);
        expect_byte(3, 8'h32);
        expect_byte(3, 8'h33);
        expect_hdr(0);
        expect_byte(0, 8'h05);
        push_byte(3, 8'h31, 1'b0);
        wait_q(3, 0, "t3_byte1");
        wait_busy(1'b1, "t3_busy_hi");
        wait_busy(1'b0, "t3_busy_lo");
        push_byte(0, 8'h05, 1'b1);
        w0 = n_wr;
        repeat (20) @(negedge sys_clk_i);
        check("t3_gap_grant", 32'(arb_grant_o), 32'h8);
        check("t3_gap_ready", 32'(req_ready_o), 32'h8);
        check("t3_gap_no_wr", 32'(n_wr - w0), 32'd0);
        push_byte(3, 8'h32, 1'b0);
        push_byte(3, 8'h33, 1'b1);
        wait_idle("t3_idle");

`ifdef UART_ARB_HDR_EN
        // Header byte for requester 2
        expect_hdr(2);
        expect_byte(2, 8'h55);
        push_byte(2, 8'h55, 1'b1);
        begin
            int t = 0;
            while (arb_active_o !== 1'b1 && t < LIM) begin
                @(negedge sys_clk_i);
                t++;
            end
            check("hdr_active", 32'(t < LIM), 32'd1);
        end
        check("hdr_ready_low", 32'(req_ready_o), 32'd0);
        @(negedge sys_clk_i);
        check("hdr_wr", 32'(uart_wr_o), 32'd1);
        check("hdr_ready_low_wr", 32'(req_ready_o), 32'd0);
        wait_idle("hdr_idle");
`endif

        // Reset during DRAIN of byte 2 of a 4-byte packet
        expect_hdr(1);
        expect_byte(1, 8'h61);
        expect_byte(1, 8'h62);
        push_byte(1, 8'h61, 1'b0);
        push_byte(1, 8'h62, 1'b0);
        push_byte(1, 8'h63, 1'b0);
        push_byte(1, 8'h64, 1'b1);
        wait_q(1, 2, "t5_two_bytes");
        wait_busy(1'b1, "t5_drain");
        #1 sys_rst_i = 1'b1;
        src_q[1].delete();
        #1;
        check("t5_rst_wr", 32'(uart_wr_o), 32'd0);
        check("t5_rst_dat", 32'(uart_dat_o), 32'd0);
        check("t5_rst_ready", 32'(req_ready_o), 32'd0);
        check("t5_rst_grant", 32'(arb_grant_o), 32'd0);
        check("t5_rst_active", 32'(arb_active_o), 32'd0);
        check("t5_no_pending", 32'(exp_q.size()), 32'd0);
        expect_hdr(0);
        expect_byte(0, 8'h70);
        push_byte(0, 8'h70, 1'b1);
        repeat (3) @(posedge sys_clk_i);
        #2 sys_rst_i = 1'b0;
        wait_idle("t5_idle");

        // Busy held high for 200 cycles mid-packet
        expect_hdr(2);
        expect_byte(2, 8'h77);
        expect_byte(2, 8'h78);
        push_byte(2, 8'h77, 1'b0);
        push_byte(2, 8'h78, 1'b1);
        wait_q(2, 1, "t6_first");
        @(negedge sys_clk_i);
        force_busy = 1'b1;
        w0 = n_wr;
        repeat (200) @(negedge sys_clk_i);
        check("t6_no_wr_busy", 32'(n_wr - w0), 32'd0);
        check("t6_grant_held", 32'(arb_grant_o), 32'h4);
        force_busy = 1'b0;
        wait_idle("t6_idle");
        check("end_grant", 32'(arb_grant_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
